pwm_dead_time_gen: RTL and testbench

Downstream consumer of the free-running mod-N counter value. It compares the count against a double-buffered duty value and produces a complementary high/low gate pair with programmable dead time. Duty updates arrive over a valid/ready handshake and take effect only at the counter's period boundary, so a period is never torn. The block also emits period and load strobes for software and neighbouring stages.

---
 rtl/pwm_dead_time_gen.sv | 111 +++++++++++
 tb/tb_pwm_dead_time_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dead_time_gen.sv
// Complementary PWM gate pair with dead-time insertion, driven by an external
// mod-N count; duty is double-buffered and swapped only at the period boundary.
module pwm_dead_time_gen #(
  parameter int N     = 12,
  parameter int WIDTH = 4,
  parameter int DT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   duty_data,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_tick,
  output logic             load_tick
);

  typedef enum logic [1:0] {LOW, DEAD_LH, HIGH, DEAD_HL} state_e;

  localparam logic [WIDTH:0]   NMAX = (WIDTH+1)'(N);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(N-1);
  localparam logic [3:0]       DTV  = 4'(DT);

  logic [WIDTH:0] active_q, active_d;
  logic [WIDTH:0] pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic           raw_q, raw_d;
  logic           ptick_q, ltick_q, ltick_d;
  state_e         state_q, state_d;
  logic [3:0]     dcnt_q, dcnt_d;
  logic           wrap, accept;

  assign wrap       = (count == LAST);
  assign duty_ready = reset & ~pend_vld_q;
  assign accept     = duty_valid & duty_ready;
  assign raw_d      = ({1'b0, count} < active_q);

  // Swap at the wrap is exclusive with an accept: pending full means not ready.
  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ltick_d    = 1'b0;
    if (wrap && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
      ltick_d    = 1'b1;
    end
    if (accept) begin
      pend_d     = (duty_data > NMAX) ? NMAX : duty_data;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      LOW: if (raw_q) begin
        state_d = (DT == 0) ? HIGH : DEAD_LH;
        dcnt_d  = DTV;
      end
      DEAD_LH: begin
        if (!raw_q)            state_d = LOW;
        else if (dcnt_q <= 1)  state_d = HIGH;
        else                   dcnt_d  = dcnt_q - 4'd1;
      end
      HIGH: if (!raw_q) begin
        state_d = (DT == 0) ? LOW : DEAD_HL;
        dcnt_d  = DTV;
      end
      // A raw pulse shorter than the dead time falls back without crossing over.
      DEAD_HL: begin
        if (raw_q)             state_d = HIGH;
        else if (dcnt_q <= 1)  state_d = LOW;
        else                   dcnt_d  = dcnt_q - 4'd1;
      end
      default: state_d = DEAD_HL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      raw_q      <= 1'b0;
      ptick_q    <= 1'b0;
      ltick_q    <= 1'b0;
      state_q    <= DEAD_HL;
      dcnt_q     <= DTV;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      raw_q      <= raw_d;
      ptick_q    <= wrap;
      ltick_q    <= ltick_d;
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign pwm_h       = (state_q == HIGH);
  assign pwm_l       = (state_q == LOW);
  assign period_tick = ptick_q;
  assign load_tick   = ltick_q;

endmodule

// File: tb/tb_pwm_dead_time_gen.sv
// Directed bench: DT=1 and DT=2 instances share one count/duty stream; gate
// activity is tallied per 12-cycle window and compared to hand-derived figures.
module tb_pwm_dead_time_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count = 4'd10;
  logic [4:0] duty_data = '0;
  logic       duty_valid = 1'b0;
  logic       duty_ready, pwm_h, pwm_l, period_tick, load_tick;
  logic       rdy2, pwm_h2, pwm_l2, pt2, lt2;

  int  checks = 0, errors = 0, cyc = 0;
  int  hi, lo, dead, pt, lt, hi2, lo2, dead2;
  int  ovl_total = 0;
  int  lt_last = 0, lt_prev = 0;
  bit  hold_cnt = 1'b0;
  logic [3:0] samp;

  pwm_dead_time_gen #(.N(12), .WIDTH(4), .DT(1)) u_dut (
    .clk(clk), .reset(reset), .count(count), .duty_data(duty_data),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_h(pwm_h),
    .pwm_l(pwm_l), .period_tick(period_tick), .load_tick(load_tick));

  pwm_dead_time_gen #(.N(12), .WIDTH(4), .DT(2)) u_dt2 (
    .clk(clk), .reset(reset), .count(count), .duty_data(duty_data),
    .duty_valid(duty_valid), .duty_ready(rdy2), .pwm_h(pwm_h2),
    .pwm_l(pwm_l2), .period_tick(pt2), .load_tick(lt2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hi = 0; lo = 0; dead = 0; pt = 0; lt = 0; hi2 = 0; lo2 = 0; dead2 = 0;
  endtask

  // One clock: DUT samples 'samp', outputs observed 1ns later, counter advances.
  task automatic step();
    samp = count;
    @(posedge clk); #1;
    if (!hold_cnt) count = (count == 4'd11) ? 4'd0 : count + 4'd1;
    cyc++;
    hi  += int'(pwm_h);  lo  += int'(pwm_l);  dead  += int'(!pwm_h && !pwm_l);
    hi2 += int'(pwm_h2); lo2 += int'(pwm_l2); dead2 += int'(!pwm_h2 && !pwm_l2);
    pt  += int'(period_tick);
    if (pwm_h && pwm_l)   ovl_total++;
    if (pwm_h2 && pwm_l2) ovl_total++;
    if (load_tick) begin lt++; lt_prev = lt_last; lt_last = cyc; end
  endtask

  task automatic to_wrap();
    int n = 0;
    do begin step(); n++; end while (samp != 4'd11 && n < 30);
    check("wrap_reached", int'(samp), 11);
  endtask

  task automatic window();
    clr();
    repeat (12) step();
  endtask

  task automatic set_duty(input int v);
    check("ready_before_write", int'(duty_ready), 1);
    duty_data = 5'(v); duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check("ready_after_write", int'(duty_ready), 0);
  endtask

  task automatic load_duty(input int v);
    set_duty(v);
    to_wrap();
    check("load_tick_at_wrap", int'(load_tick), 1);
    check("period_tick_at_wrap", int'(period_tick), 1);
    check("ready_after_load", int'(duty_ready), 1);
    step();
    check("load_tick_one_cycle", int'(load_tick), 0);
  endtask

  task automatic win_check(input string tag, input int eh, input int el, input int ed);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dead"}, dead, ed);
  endtask

  initial begin
    // reset with counter running through a wrap
    repeat (3) begin
      step();
      check("rst_h", int'(pwm_h), 0);
      check("rst_l", int'(pwm_l), 0);
      check("rst_ready", int'(duty_ready), 0);
      check("rst_ptick", int'(period_tick), 0);
      check("rst_ltick", int'(load_tick), 0);
    end
    reset = 1'b1; #1;
    check("rel_ready", int'(duty_ready), 1);
    check("rel_l_dead", int'(pwm_l), 0);
    step();
    check("rel_l_on", int'(pwm_l), 1);
    check("rel_h_off", int'(pwm_h), 0);

    // duty 6: 5 high, 5 low, 2 dead per period
    load_duty(6);
    window();
    win_check("d6a", 5, 5, 2);
    check("d6a_ptick", pt, 1);
    check("d6a_ltick", lt, 0);
    window();
    win_check("d6b", 5, 5, 2);
    check("d6b_ptick", pt, 1);
    check("d6b_dt2_hi", hi2, 4);
    check("d6b_dt2_lo", lo2, 4);

    // duty 0: low side constant
    load_duty(0);
    window();
    win_check("d0", 0, 12, 0);

    // handshake: 3 accepted, 9 stalls until the wrap frees pending
    check("hs_ready0", int'(duty_ready), 1);
    duty_data = 5'd3; duty_valid = 1'b1;
    step();
    check("hs_ready_after3", int'(duty_ready), 0);
    duty_data = 5'd9;
    step();
    check("hs_stall", int'(duty_ready), 0);
    to_wrap();
    check("hs_lt_first", int'(load_tick), 1);
    check("hs_ready_at_wrap", int'(duty_ready), 1);
    step();
    duty_valid = 1'b0;
    check("hs_9_accepted", int'(duty_ready), 0);
    check("hs_lt_single", int'(load_tick), 0);
    window();
    win_check("d3", 2, 8, 2);
    check("hs_lt_second", lt, 1);
    check("hs_lt_gap", lt_last - lt_prev, 12);
    window();
    win_check("d9", 8, 2, 2);

    // duty 12: full high after one dead cycle
    load_duty(12);
    window();
    win_check("d12a", 11, 0, 1);
    window();
    win_check("d12b", 12, 0, 0);

    // duty 15 clamps to 12
    load_duty(15);
    window();
    win_check("d15", 12, 0, 0);
    // count 13 never wraps; compared against the clamped 12, so raw drops
    clr();
    hold_cnt = 1'b1; count = 4'd13;
    repeat (4) step();
    check("c13_l", int'(pwm_l), 1);
    check("c13_h", int'(pwm_h), 0);
    check("c13_no_ptick", pt, 0);
    hold_cnt = 1'b0; count = 4'd0;

    // duty 1: raw pulse shorter than/equal to dead time never drives high side
    load_duty(1);
    window();
    window();
    win_check("d1", 0, 11, 1);
    check("d1_dt2_hi", hi2, 0);
    check("d1_dt2_lo", lo2, 11);
    check("d1_dt2_dead", dead2, 1);

    // reset mid-period with pending full
    set_duty(5);
    step();
    reset = 1'b0;
    step();
    check("mrst_h", int'(pwm_h), 0);
    check("mrst_l", int'(pwm_l), 0);
    check("mrst_ready", int'(duty_ready), 0);
    check("mrst_ptick", int'(period_tick), 0);
    step();
    reset = 1'b1; #1;
    check("mrst_pending_lost", int'(duty_ready), 1);
    step();
    check("mrst_l_on", int'(pwm_l), 1);
    to_wrap();
    check("mrst_no_load", int'(load_tick), 0);
    check("mrst_ptick_wrap", int'(period_tick), 1);
    window();
    win_check("mrst", 0, 12, 0);

    check("no_overlap", ovl_total, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
